alu_share_arb: RTL and testbench

Round-robin arbiter that shares one `ALU` instance between the two issue slots of the dual-issue pipeline. Each slot presents an operation (op code, operands) with a valid/ready handshake. The block grants one slot per cycle, drives the ALU, and registers the result plus overflow flag into a single-entry output buffer. The buffer is returned on one response channel tagged with the owning slot. It sits between decode/issue and the EX/MEM pipeline register whenever only one ALU is built.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_share_arb_alu.sv | 48 ++++
 rtl/alu_share_arb.sv | 124 ++++++++++++
 tb/tb_alu_share_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op code constants, slot id type and result-buffer states.
package alu_pkg;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b01000;
    localparam logic [4:0] ALU_NOR = 5'b10000;
    localparam logic [4:0] ALU_XOR = 5'b11000;
    localparam logic [4:0] ALU_ADD = 5'b00001;
    localparam logic [4:0] ALU_SUB = 5'b01001;
    localparam logic [4:0] ALU_SLT = 5'b01010;
    localparam logic [4:0] ALU_SRL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b01100;
    localparam logic [4:0] ALU_SLL = 5'b10100;
    localparam logic [4:0] ALU_LUI = 5'b11100;

    typedef logic slot_id_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Pointer value after reset, so slot 0 wins the first tie.
    localparam slot_id_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Shared combinational ALU. int_ov_o is the carry of ADD and the borrow of SUB.
module ALU
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_o,
    output logic        int_ov_o
);

    // Clock and reset are part of the legacy port list but the datapath is purely combinational.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    logic [32:0] sum;
    logic [32:0] diff;

    always_comb begin
        res_o    = '0;
        int_ov_o = 1'b0;
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        case (op_i)
            ALU_AND: res_o = a_i & b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_NOR: res_o = ~(a_i | b_i);
            ALU_XOR: res_o = a_i ^ b_i;
            ALU_ADD: begin
                res_o    = sum[31:0];
                int_ov_o = sum[32];
            end
            ALU_SUB: begin
                res_o    = diff[31:0];
                int_ov_o = diff[32];
            end
            ALU_SLT: res_o = {31'b0, ($signed(a_i) < $signed(b_i))};
            ALU_SRL: res_o = a_i >> b_i[4:0];
            ALU_SRA: res_o = $signed(a_i) >>> b_i[4:0];
            ALU_SLL: res_o = a_i << b_i[4:0];
            ALU_LUI: res_o = {b_i[15:0], 16'h0000};
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU between two issue slots, with a single-entry
// registered result buffer and a saturating count of cycles a valid slot was stalled.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [4:0]       req_op0,
    input  logic [4:0]       req_op1,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_data,
    output logic             resp_ov,
    output logic [CNT_W-1:0] conflict_cnt
);

    buf_state_e       state_q, state_d;
    slot_id_t         buf_id_q, buf_id_d;
    logic [31:0]      buf_data_q, buf_data_d;
    logic             buf_ov_q, buf_ov_d;
    slot_id_t         last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        grant_valid;
    slot_id_t    grant;
    logic        out_free;
    logic        accept;
    logic        conflict;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_int_ov;

    // A lone valid slot always wins; on a tie the pointer hands the grant to the other slot.
    assign grant_valid = |req_valid;
    assign grant       = (&req_valid) ? ~last_grant_q : req_valid[1];
    assign out_free    = (state_q == BUF_EMPTY) || resp_ready;
    assign accept      = grant_valid && out_free && !flush && !reset;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant == slot_id_t'(gi));
        end
    endgenerate

    assign conflict = |(req_valid & ~req_ready);

    assign alu_op = grant ? req_op1 : req_op0;
    assign alu_a  = grant ? req_a1  : req_a0;
    assign alu_b  = grant ? req_b1  : req_b0;

    ALU u_alu (
        .clk      (clk),
        .reset    (reset),
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .res_o    (alu_res),
        .int_ov_o (alu_int_ov)
    );

    always_comb begin
        state_d      = state_q;
        buf_id_d     = buf_id_q;
        buf_data_d   = buf_data_q;
        buf_ov_d     = buf_ov_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        if (flush) begin
            state_d = BUF_EMPTY;
        end else if (accept) begin
            state_d      = BUF_FULL;
            buf_id_d     = grant;
            buf_data_d   = alu_res;
            buf_ov_d     = alu_int_ov;
            last_grant_d = grant;
        end else if (resp_ready && (state_q == BUF_FULL)) begin
            state_d = BUF_EMPTY;
        end

        // Stalls under flush still count; the counter sticks at all-ones.
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BUF_EMPTY;
            buf_id_q     <= 1'b0;
            buf_data_q   <= '0;
            buf_ov_q     <= 1'b0;
            last_grant_q <= LAST_GRANT_RST;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            buf_id_q     <= buf_id_d;
            buf_data_q   <= buf_data_d;
            buf_ov_q     <= buf_ov_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign resp_valid   = (state_q == BUF_FULL);
    assign resp_id      = buf_id_q;
    assign resp_data    = buf_data_q;
    assign resp_ov      = buf_ov_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbiter and ALU.
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [4:0]       req_op0 = 5'd0;
    logic [4:0]       req_op1 = 5'd0;
    logic [31:0]      req_a0 = '0;
    logic [31:0]      req_a1 = '0;
    logic [31:0]      req_b0 = '0;
    logic [31:0]      req_b1 = '0;
    logic             flush = 1'b0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_id;
    logic [31:0]      resp_data;
    logic             resp_ov;
    logic [CNT_W-1:0] conflict_cnt;

    alu_share_arb #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_a1       (req_a1),
        .req_b0       (req_b0),
        .req_b1       (req_b1),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_data    (resp_data),
        .resp_ov      (resp_ov),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic print_en = 1'b1;
    logic [1:0] last_ready;

    // Behavioural model state
    logic        m_valid = 1'b0;
    logic        m_id = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_ov = 1'b0;
    logic        m_last = 1'b1;
    int          m_cnt = 0;

    logic [4:0] op_tab [11];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        logic [31:0] r;
        logic        o;
        r = 32'd0;
        o = 1'b0;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_NOR: r = ~(a | b);
            ALU_XOR: r = a ^ b;
            ALU_ADD: begin
                wide = 64'(a) + 64'(b);
                r = wide[31:0];
                o = (wide > 64'hFFFF_FFFF);
            end
            ALU_SUB: begin
                r = a - b;
                o = (a < b);
            end
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SRL: r = a / (32'd1 << b[4:0]);
            ALU_SRA: r = 32'($signed(a) >>> b[4:0]);
            ALU_SLL: r = a * (32'd1 << b[4:0]);
            ALU_LUI: r = b * 32'h0001_0000;
            default: r = 32'd0;
        endcase
        return {o, r};
    endfunction

    // One clock cycle: check req_ready before the edge, advance the model, check outputs after.
    task automatic step();
        logic        g;
        logic        acc;
        logic [1:0]  er;
        logic        conf;
        logic [32:0] res;
        #1;
        g = (req_valid == 2'b11) ? !m_last : req_valid[1];
        acc = (req_valid != 2'b00) && (!m_valid || resp_ready) && !flush && !reset;
        er = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
        check_val("req_ready", 64'(req_ready), 64'(er));
        last_ready = req_ready;
        conf = (req_valid & ~er) != 2'b00;
        res = g ? ref_alu(req_op1, req_a1, req_b1) : ref_alu(req_op0, req_a0, req_b0);
        if (acc && print_en)
            $display("TXN t=%0t slot=%0d op=%b data=%h ov=%0d", $time, g, g ? req_op1 : req_op0, res[31:0], res[32]);
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_ov = 1'b0; m_last = 1'b1; m_cnt = 0;
        end else begin
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1; m_id = g; m_data = res[31:0]; m_ov = res[32]; m_last = g;
            end else if (resp_ready) m_valid = 1'b0;
            if (conf && m_cnt < CNT_MAX) m_cnt++;
        end
        check_val("resp_valid", 64'(resp_valid), 64'(m_valid));
        check_val("resp_id", 64'(resp_id), 64'(m_id));
        check_val("resp_data", 64'(resp_data), 64'(m_data));
        check_val("resp_ov", 64'(resp_ov), 64'(m_ov));
        check_val("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    endtask

    initial begin
        op_tab = '{ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_ADD, ALU_SUB,
                   ALU_SLT, ALU_SRL, ALU_SRA, ALU_SLL, ALU_LUI};

        // Reset
        reset = 1'b1;
        step(); step();
        check_val("rst_ready", 64'(last_ready), 64'd0);
        check_val("rst_valid", 64'(resp_valid), 64'd0);
        reset = 1'b0;

        // Slot 0 alone: ADD 5+7
        req_valid = 2'b01; req_op0 = ALU_ADD; req_a0 = 32'd5; req_b0 = 32'd7; resp_ready = 1'b1;
        step();
        check_val("add_ready", 64'(last_ready), 64'b01);
        check_val("add_valid", 64'(resp_valid), 64'd1);
        check_val("add_id", 64'(resp_id), 64'd0);
        check_val("add_data", 64'(resp_data), 64'd12);
        check_val("add_ov", 64'(resp_ov), 64'd0);

        // Sustained contention after a fresh reset
        req_valid = 2'b00; reset = 1'b1; step(); reset = 1'b0;
        req_valid = 2'b11;
        req_op0 = ALU_OR;  req_a0 = 32'hF0; req_b0 = 32'h0F;
        req_op1 = ALU_SUB; req_a1 = 32'd9;  req_b1 = 32'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("rr_id", 64'(resp_id), 64'(i % 2));
            check_val("rr_data", 64'(resp_data), (i % 2) ? 64'd6 : 64'hFF);
        end
        check_val("rr_cnt", 64'(conflict_cnt), 64'd4);

        // Full buffer back-pressure, then release
        req_valid = 2'b10; resp_ready = 1'b0;
        req_op1 = ALU_ADD; req_a1 = 32'd100; req_b1 = 32'd23;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold_ready", 64'(last_ready), 64'd0);
            check_val("hold_data", 64'(resp_data), 64'd6);
            check_val("hold_id", 64'(resp_id), 64'd1);
        end
        resp_ready = 1'b1;
        step();
        check_val("release_ready", 64'(last_ready), 64'b10);
        check_val("release_data", 64'(resp_data), 64'd123);

        // Flush while full; pointer must survive it
        req_valid = 2'b01; req_op0 = ALU_ADD; req_a0 = 32'd1; req_b0 = 32'd1;
        flush = 1'b1; resp_ready = 1'b0;
        step();
        check_val("flush_ready", 64'(last_ready), 64'd0);
        check_val("flush_valid", 64'(resp_valid), 64'd0);
        flush = 1'b0; req_valid = 2'b11; resp_ready = 1'b1;
        step();
        check_val("post_flush_tie", 64'(last_ready), 64'b01);
        check_val("post_flush_data", 64'(resp_data), 64'd2);

        // Arithmetic corners
        req_valid = 2'b01; req_op0 = ALU_ADD; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1;
        step();
        check_val("carry_data", 64'(resp_data), 64'd0);
        check_val("carry_ov", 64'(resp_ov), 64'd1);
        req_op0 = ALU_LUI; req_a0 = 32'd0; req_b0 = 32'h1234;
        step();
        check_val("lui_data", 64'(resp_data), 64'h1234_0000);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            req_valid  = 2'($urandom_range(0, 3));
            req_op0    = op_tab[$urandom_range(0, 10)];
            req_op1    = op_tab[$urandom_range(0, 10)];
            req_a0     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            req_a1     = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            req_b0     = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
            req_b1     = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0;

        // Counter saturation under permanent conflict, then reset mid-run
        print_en = 1'b0;
        req_valid = 2'b11; resp_ready = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) step();
        check_val("sat_cnt", 64'(conflict_cnt), 64'(CNT_MAX));
        print_en = 1'b1;
        reset = 1'b1;
        step();
        check_val("midrst_ready", 64'(last_ready), 64'd0);
        check_val("midrst_valid", 64'(resp_valid), 64'd0);
        check_val("midrst_id", 64'(resp_id), 64'd0);
        check_val("midrst_data", 64'(resp_data), 64'd0);
        check_val("midrst_ov", 64'(resp_ov), 64'd0);
        check_val("midrst_cnt", 64'(conflict_cnt), 64'd0);
        reset = 1'b0; resp_ready = 1'b1;
        step();
        check_val("midrst_tie", 64'(last_ready), 64'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
